// File: rtl/zbb_count_if.sv
// Issue/writeback handshake bundle for the Zbb count unit.
// The master drives requests and out_ready; the slave is the execute unit.
interface zbb_count_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op;
    logic [DATA_WIDTH-1:0] in_operand;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [TAG_W-1:0]      out_tag;

    modport master (
        output in_valid, in_op, in_operand, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_operand, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/zbb_count_unit.sv
// Two-stage execute unit for Zbb CLZ/CTZ/CPOP: S1 captures (bit-reversed for CLZ),
// S2 computes the count and holds it in a valid/ready output register.
module zbb_count_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    zbb_count_if.slave  bus
);
    localparam logic [1:0] OP_CLZ  = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;

    logic                  s1_valid_reg;
    logic [1:0]            s1_op_reg;
    logic [DATA_WIDTH-1:0] s1_operand_reg;
    logic [DATA_WIDTH-1:0] s1_operand_next;
    logic [DATA_WIDTH-1:0] operand_rev;
    logic [TAG_W-1:0]      s1_tag_reg;
    logic                  s2_valid_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [DATA_WIDTH-1:0] result_next;
    logic [TAG_W-1:0]      tag_reg;
    logic                  s2_adv;
    logic                  s1_adv;
    logic                  in_ready_int;
    logic [5:0]            tz_count;
    logic [5:0]            pop_count;
    logic [5:0]            count;

    assign s2_adv       = !s2_valid_reg | bus.out_ready;
    assign s1_adv       = s1_valid_reg & s2_adv;
    assign in_ready_int = !s1_valid_reg | s2_adv;

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = s2_valid_reg;
    assign bus.out_result = result_reg;
    assign bus.out_tag    = tag_reg;

    // CLZ(x) == CTZ(reverse(x)), so only one encoder is needed downstream.
    genvar gi;
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
        assign operand_rev[gi] = bus.in_operand[DATA_WIDTH-1-gi];
    end

    assign s1_operand_next = (bus.in_op == OP_CLZ) ? operand_rev : bus.in_operand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= 2'b00;
            s1_operand_reg <= '0;
            s1_tag_reg     <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready_int) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_reg      <= bus.in_op;
                s1_operand_reg <= s1_operand_next;
                s1_tag_reg     <= bus.in_tag;
            end
        end
    end

    // Trailing-zero encoder: the lowest set bit wins; all-zero yields 32.
    always_comb begin
        tz_count = 6'd32;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (s1_operand_reg[i]) tz_count = i[5:0];
        end
    end

    logic [1:0] pop_l1 [16];
    logic [2:0] pop_l2 [8];
    logic [3:0] pop_l3 [4];
    logic [4:0] pop_l4 [2];

    for (gi = 0; gi < 16; gi++) begin : g_pop_l1
        assign pop_l1[gi] = {1'b0, s1_operand_reg[2*gi]} + {1'b0, s1_operand_reg[2*gi+1]};
    end
    for (gi = 0; gi < 8; gi++) begin : g_pop_l2
        assign pop_l2[gi] = {1'b0, pop_l1[2*gi]} + {1'b0, pop_l1[2*gi+1]};
    end
    for (gi = 0; gi < 4; gi++) begin : g_pop_l3
        assign pop_l3[gi] = {1'b0, pop_l2[2*gi]} + {1'b0, pop_l2[2*gi+1]};
    end
    for (gi = 0; gi < 2; gi++) begin : g_pop_l4
        assign pop_l4[gi] = {1'b0, pop_l3[2*gi]} + {1'b0, pop_l3[2*gi+1]};
    end
    assign pop_count = {1'b0, pop_l4[0]} + {1'b0, pop_l4[1]};

    always_comb begin
        count = 6'd0;
        case (s1_op_reg)
            OP_CLZ, OP_CTZ: count = tz_count;
            OP_CPOP:        count = pop_count;
            default:        count = 6'd0;
        endcase
    end

    assign result_next = {{(DATA_WIDTH-6){1'b0}}, count};

    // Result/tag registers move only on an S2 load, so a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            result_reg   <= '0;
            tag_reg      <= '0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_adv) begin
                result_reg <= result_next;
                tag_reg    <= s1_tag_reg;
            end
        end
    end
endmodule
